// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser and centre-of-bit sampling.
// Ports: clk        - system clock, rising edge
//        rst_n      - asynchronous active-low reset
//        rxd        - serial line, idle high, asynchronous to clk
//        data_out   - last correctly framed byte, LSB received first
//        data_valid - one-cycle strobe, data_out updated this cycle
//        frame_err  - one-cycle strobe, stop bit sampled low
//        busy       - high whenever the receiver is not idle
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
   state_t        state;
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          rx_s;
   assign rx_s = sync[1];
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= 2'b11;
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[0], rxd};
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE:
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            START:
               if (cnt == HALF_END) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else cnt <= cnt + 1'b1;
            DATA:
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else cnt <= cnt + 1'b1;
            STOP:
               if (cnt == BIT_END) begin
                  cnt <= '0;
                  // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                  if (rx_s) begin
                     data_out   <= shift;
                     data_valid <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else cnt <= cnt + 1'b1;
            // A break or stuck-low line must not decode as repeated 0x00 frames.
            WAIT_HIGH: if (rx_s) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream stage of the UART transmitter. Consumes the serial line that the transmitter drives on txd.
- Synchronises rxd into the clk domain, validates the start bit and samples each bit at its centre. Presents each received byte with a one-cycle valid strobe.
- Defaults target a 50 MHz clock and 115200 baud, the same operating point as the transmitter.

Parameters:
- CLKS_PER_BIT, 434, clocks per bit period (50_000_000/115200, floored); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (217), clocks from start-edge detection to the start-bit centre sample.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last correctly framed byte, LSB received first.
- data_valid  output  1  one-cycle strobe: data_out updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops = 1; state = IDLE; counters = 0; shift register = 0.
  - data_out = 8'h00; data_valid = 0; frame_err = 0; busy = 0.
- Synchroniser: 2-flop chain on rxd gives rx_s. All decisions use rx_s only.
- Bit counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- IDLE:
  - If rx_s == 0, go to START with the counter cleared. Call this edge t0.
- START:
  - Count to HALF_BIT-1, then sample at t0+HALF_BIT.
  - If rx_s == 0, go to DATA with counter = 0 and bit_idx = 0.
  - If rx_s == 1, treat as a glitch: go to IDLE with no strobe.
- DATA:
  - Sample bit i at t0+HALF_BIT+(i+1)*CLKS_PER_BIT.
  - Shift right: shift[7] <= rx_s. After 8 samples, shift[0] holds the first-received bit.
  - After bit 7, go to STOP.
- STOP: sample at t0+HALF_BIT+9*CLKS_PER_BIT.
  - If rx_s == 1:
    - data_out <= shift; data_valid = 1 for exactly the next cycle.
    - Go to IDLE immediately, at the centre of the stop bit, so the next start edge is accepted.
  - If rx_s == 0:
    - frame_err = 1 for exactly the next cycle; data_out is unchanged.
    - Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This keeps a break or stuck-low line from being decoded as repeated 0x00 frames.
- Strobes:
  - data_valid and frame_err are never high together.
  - Neither is asserted outside a STOP-state sample.
- data_out holds its value until the next good frame. There is no consumer handshake: a byte not captured on the data_valid cycle is overwritten by the next frame, with no overrun flag.
- Reset asserted mid-frame: immediate return to the reset values, with no strobe.
- After reset release: a line already low when reset releases is treated as a start edge. A line held low for a full frame therefore yields frame_err, then WAIT_HIGH.
- Latency from the start edge reaching rx_s to data_valid: HALF_BIT + 9*CLKS_PER_BIT + 1 clocks (4124 at defaults). Add 2 clocks from rxd to rx_s.

Test Plan:
- Loopback:
  - Stimulus: UART transmitter txd drives rxd, sending 0xA5 then 0x3C.
  - Response: data_valid pulses once per byte; data_out = 8'hA5, then 8'h3C; frame_err stays 0.
  - Response: data_valid rises 4126 +/- 1 clocks after txd falls (2 sync + latency).
- Start glitch:
  - Stimulus: rxd low for 100 ns (5 clocks), then high.
  - Response: busy high, then back to 0 within HALF_BIT+3 clocks; no data_valid; no frame_err; data_out unchanged.
- Framing error:
  - Stimulus: bit-banged frame of 0x5A with the stop bit driven 0, line held low 2 more bit times, then high.
  - Response: frame_err pulses for 1 cycle; data_out still 8'h3C; busy stays high until rx_s returns to 1.
  - Response: a following good frame 0x81 gives data_valid with data_out = 8'h81.
- Back-to-back:
  - Stimulus: frames 0x00, 0xFF, 0x55 with no idle gap between stop and start bits.
  - Response: three data_valid pulses with the values in order; no frame_err.
- Reset mid-frame:
  - Stimulus: rst_n pulled low during data bit 4 of 0xC3, then released with the line idle.
  - Response: all outputs at reset values; no strobe.
  - Response: the next frame 0x96 is received correctly.
- Baud tolerance:
  - Stimulus: transmitter model at 425 and at 443 clocks/bit (about +/-2%), sending 0xA5.
  - Response: data_out = 8'hA5 with data_valid in both cases.
